// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between two MIPS pipeline stages and the stage buffer that sits between them.
// The buffer takes the slave modport; the surrounding stages (or a bench) take the master modport.
interface pipe_stage_buf_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int EXC_W  = 5,
   parameter int DEPTH  = 2
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc;
   logic [DATA_W-1:0] in_data;
   logic [EXC_W-1:0]  in_exc;
   logic              in_bd;

   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [DATA_W-1:0] out_data;
   logic [EXC_W-1:0]  out_exc;
   logic              out_bd;

   logic [CNT_W-1:0]  count;

   modport slave (
      input  in_valid, in_pc, in_data, in_exc, in_bd, out_ready,
      output in_ready, out_valid, out_pc, out_data, out_exc, out_bd, count
   );

   modport master (
      output in_valid, in_pc, in_data, in_exc, in_bd, out_ready,
      input  in_ready, out_valid, out_pc, out_data, out_exc, out_bd, count
   );
endinterface

// File: rtl/pipe_stage_buf.sv
// DEPTH-entry elastic buffer between pipeline stages with req/eret flush and a held bubble PC.
// Optional combinational empty-buffer bypass is enabled by defining PIPE_STAGE_BUF_BYPASS_EN.
module pipe_stage_buf #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int EXC_W  = 5,
   parameter int DEPTH  = 2,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_3000),
   parameter logic [PC_W-1:0] EXC_PC   = PC_W'(32'h0000_4180)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              eret,
   pipe_stage_buf_if.slave   bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [PC_W-1:0]   pcMem_q   [DEPTH];
   logic [DATA_W-1:0] dataMem_q [DEPTH];
   logic [EXC_W-1:0]  excMem_q  [DEPTH];
   logic              bdMem_q   [DEPTH];

   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PC_W-1:0]   pcHold_q, pcHold_d;

   logic headValid;
   logic bypass;
   logic bypassTaken;
   logic push;
   logic pop;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // in_ready looks only at registered occupancy so out_ready never reaches it combinationally.
   assign headValid   = (count_q != '0);
   assign bus.in_ready = (count_q < DEPTH_C);
   assign bus.count    = count_q;

`ifdef PIPE_STAGE_BUF_BYPASS_EN
   assign bypass = !headValid && bus.in_valid && !req && !eret;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed entry that is accepted downstream is never written into storage.
   assign bypassTaken = bypass && bus.out_ready;
   assign pop         = headValid && bus.out_ready;
   assign push        = bus.in_valid && bus.in_ready && !bypassTaken;

   always_comb begin
      bus.out_valid = headValid || bypass;
      bus.out_pc    = pcHold_q;
      bus.out_data  = '0;
      bus.out_exc   = '0;
      bus.out_bd    = 1'b0;
      if (headValid) begin
         bus.out_pc   = pcMem_q[rdPtr_q];
         bus.out_data = dataMem_q[rdPtr_q];
         bus.out_exc  = excMem_q[rdPtr_q];
         bus.out_bd   = bdMem_q[rdPtr_q];
      end else if (bypass) begin
         bus.out_pc   = bus.in_pc;
         bus.out_data = bus.in_data;
         bus.out_exc  = bus.in_exc;
         bus.out_bd   = bus.in_bd;
      end
   end

   // Flushes outrank traffic; only req redirects the bubble PC, eret keeps the last popped PC.
   always_comb begin
      rdPtr_d  = rdPtr_q;
      wrPtr_d  = wrPtr_q;
      count_d  = count_q;
      pcHold_d = pcHold_q;
      if (req) begin
         rdPtr_d  = '0;
         wrPtr_d  = '0;
         count_d  = '0;
         pcHold_d = EXC_PC;
      end else if (eret) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (push) begin
            wrPtr_d = nextPtr(wrPtr_q);
         end
         if (pop) begin
            rdPtr_d  = nextPtr(rdPtr_q);
            pcHold_d = pcMem_q[rdPtr_q];
         end else if (bypassTaken) begin
            pcHold_d = bus.in_pc;
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdPtr_q  <= '0;
         wrPtr_q  <= '0;
         count_q  <= '0;
         pcHold_q <= RESET_PC;
      end else begin
         rdPtr_q  <= rdPtr_d;
         wrPtr_q  <= wrPtr_d;
         count_q  <= count_d;
         pcHold_q <= pcHold_d;
      end
   end

   // Entry storage needs no reset: count_q alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (push && !req && !eret) begin
         pcMem_q[wrPtr_q]   <= bus.in_pc;
         dataMem_q[wrPtr_q] <= bus.in_data;
         excMem_q[wrPtr_q]  <= bus.in_exc;
         bdMem_q[wrPtr_q]   <= bus.in_bd;
      end
   end
endmodule
